// File: rtl/lcg_rewind.sv
// lcg_rewind: backward stepper for the 64-bit shift-add LCG
//   forward:  q(i+1) = q(i) + (q(i) << r) + b   (mod 2^64)
//   backward: q(i)   = (q(i+1) - b) * (1 + 2^r)^-1, where the inverse is the
//             alternating series 1 - 2^r + 2^2r - ..., applied one term per cycle.
// Optional feature: define LCG_REWIND_FWD_CHECK_EN to re-run the forward step
// on each result and flag a mismatch against the pre-step state on chk_fail.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          load q_in / a / b, abort any step in progress (beats step)
//   step           request one backward step (taken only when idle)
//   q_in, a, b     seed state, forward multiplier (r from highest set bit of a[63:1]), increment
//   q_out          current rewound state
//   busy           step in progress
//   done           one-cycle completion pulse
//   err            with done: step refused because r = 0
//   chk_fail       with done: forward re-check mismatch (0 without the macro)
module lcg_rewind (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [63:0] q_in,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] q_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        chk_fail
);

  localparam int unsigned W  = 64;
  localparam int unsigned RW = 6;
  localparam int unsigned SW = 7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [RW-1:0] r_q, r_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [SW-1:0] s_q, s_d;
  logic          neg_q, neg_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [W-1:0]  acc_n;
  logic [SW-1:0] s_sum;
  logic [W-1:0]  diff;
  logic [W-1:0]  a_hi;
  logic [RW-1:0] r_enc;

  // Shift amount: index of the highest set bit of a, ignoring bit 0
  function automatic logic [RW-1:0] enc_r(input logic [W-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 1; i < 64; i++) begin
      if (v[i]) r = RW'(i);
    end
    return r;
  endfunction

  assign a_hi  = a & ~W'(1);
  assign r_enc = enc_r(a_hi);

`ifdef LCG_REWIND_FWD_CHECK_EN
  logic [W-1:0] shadow_q, shadow_d;
  logic         chk_q, chk_d;
  logic [W-1:0] fwd;

  // Forward step applied to the value about to be committed
  assign fwd = acc_n + (acc_n << r_q) + b_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      s_q     <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LCG_REWIND_FWD_CHECK_EN
      shadow_q <= '0;
      chk_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      s_q     <= s_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LCG_REWIND_FWD_CHECK_EN
      shadow_q <= shadow_d;
      chk_q    <= chk_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    s_d     = s_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef LCG_REWIND_FWD_CHECK_EN
    shadow_d = shadow_q;
    chk_d    = 1'b0;
`endif

    acc_n = neg_q ? (acc_q - sh_q) : (acc_q + sh_q);
    s_sum = s_q + SW'(r_q);
    diff  = q_q - b_q;

    if (start) begin
      q_d     = q_in;
      r_d     = r_enc;
      b_d     = b;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (step) begin
            if (r_q != '0) begin
              // Term 0 of the series goes straight into acc
              acc_d   = diff;
              sh_d    = diff << r_q;
              s_d     = SW'(r_q);
              neg_d   = 1'b1;
              state_d = RUN;
`ifdef LCG_REWIND_FWD_CHECK_EN
              shadow_d = q_q;
`endif
            end else begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          end
        end
        RUN: begin
          acc_d = acc_n;
          sh_d  = sh_q << r_q;
          s_d   = s_sum;
          neg_d = ~neg_q;
          // Further terms are shifted entirely out of 64 bits
          if (s_sum >= SW'(64)) begin
            q_d     = acc_n;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef LCG_REWIND_FWD_CHECK_EN
            chk_d = (fwd != shadow_q);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign q_out = q_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign err   = err_q;
`ifdef LCG_REWIND_FWD_CHECK_EN
  assign chk_fail = chk_q;
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_lcg_rewind.sv
// Testbench for lcg_rewind: vector table, random forward/rewind walks
// against a multiplicative inverse model, and hand-written corner sequences.
module tb_lcg_rewind;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        step;
  logic [63:0] q_in;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] q_out;
  logic        busy;
  logic        done;
  logic        err;
  logic        chk_fail;

  int errors = 0;
  int checks = 0;

  lcg_rewind dut (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .q_in(q_in), .a(a), .b(b),
    .q_out(q_out), .busy(busy), .done(done), .err(err), .chk_fail(chk_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_q;
    int          lat;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  // ---------------- reference model ----------------
  function automatic int m_r(input logic [63:0] av);
    int r;
    r = 0;
    for (int i = 1; i < 64; i++) if (av[i]) r = i;
    return r;
  endfunction

  // Newton iteration for the inverse of an odd number mod 2^64
  function automatic logic [63:0] m_inv(input logic [63:0] m);
    logic [63:0] x;
    x = 64'd1;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - m * x);
    return x;
  endfunction

  function automatic logic [63:0] m_mult(input int r);
    return 64'd1 + (64'd1 << r);
  endfunction

  function automatic logic [63:0] m_prev(input logic [63:0] q, input int r, input logic [63:0] bv);
    return (q - bv) * m_inv(m_mult(r));
  endfunction

  function automatic logic [63:0] m_fwd(input logic [63:0] q, input int r, input logic [63:0] bv);
    return q * m_mult(r) + bv;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [63:0] qv, input logic [63:0] av, input logic [63:0] bv);
    start = 1'b1; q_in = qv; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue step at a negedge; lat counts edges until done is seen
  task automatic run_step(output int lat, output logic to, output logic busy_seen,
                          output logic err_v, output logic chk_v, output logic done_after);
    step = 1'b1;
    lat = 0; busy_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      step = 1'b0;
      lat++;
      if (busy) busy_seen = 1'b1;
      if (done) break;
    end
    to    = !done;
    err_v = err;
    chk_v = chk_fail;
    @(negedge clk);
    done_after = done;
  endtask

  initial begin
    int lat;
    logic to, bs, ev, cv, da;
    logic [63:0] seq[21];
    int rs[5];
    int r, cnt;
    logic seen;

    rst = 1'b1; start = 1'b0; step = 1'b0; q_in = '0; a = '0; b = '0;

    tbl[0] = '{64'd16, 64'd3, 64'd1, 64'd5, 64, 1'b0};
    tbl[1] = '{64'h117, 64'h11, 64'd7, 64'h10, 16, 1'b0};
    tbl[2] = '{64'hDEADBEEFCAFEF00D, (64'd1 << 21) | 64'd1, 64'h1234,
               m_prev(64'hDEADBEEFCAFEF00D, 21, 64'h1234), 4, 1'b0};
    tbl[3] = '{64'h0123456789ABCDEF, 64'h8000000000000001, 64'd3,
               m_prev(64'h0123456789ABCDEF, 63, 64'd3), 2, 1'b0};
    tbl[4] = '{64'h77, 64'd1, 64'd9, 64'h77, 1, 1'b1};
    tbl[5] = '{64'h1000, 64'h13, 64'd0, m_prev(64'h1000, 4, 64'd0), 16, 1'b0};
    tbl[6] = '{64'hABC, 64'd0, 64'd5, 64'hABC, 1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_q_out", q_out, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_chk", 64'(chk_fail), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      do_start(tbl[i].q, tbl[i].a, tbl[i].b);
      run_step(lat, to, bs, ev, cv, da);
      chk($sformatf("tbl%0d_timeout", i), 64'(to), 64'd0);
      chk($sformatf("tbl%0d_q", i), q_out, tbl[i].exp_q);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_err", i), 64'(ev), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_chk", i), 64'(cv), 64'd0);
      chk($sformatf("tbl%0d_busy", i), 64'(bs), 64'(!tbl[i].exp_err));
      chk($sformatf("tbl%0d_pulse", i), 64'(da), 64'd0);
    end

    // Second consecutive step from 0x10
    do_start(64'h117, 64'h11, 64'd7);
    run_step(lat, to, bs, ev, cv, da);
    run_step(lat, to, bs, ev, cv, da);
    chk("step2_q", q_out, 64'h7878787878787879);
    chk("step2_fwd", m_fwd(q_out, 4, 64'd7), 64'h10);
    chk("step2_lat", 64'(lat), 64'd16);

    // Random forward walks, rewound step by step
    rs = '{1, 7, 21, 32, 63};
    for (int ri = 0; ri < 5; ri++) begin
      logic [63:0] bv, av;
      r = rs[ri];
      seq[0] = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      av = m_mult(r);
      for (int k = 1; k <= 20; k++) seq[k] = m_fwd(seq[k-1], r, bv);
      do_start(seq[20], av, bv);
      for (int k = 19; k >= 0; k--) begin
        run_step(lat, to, bs, ev, cv, da);
        chk($sformatf("rnd_r%0d_k%0d_q", r, k), q_out, seq[k]);
        chk($sformatf("rnd_r%0d_k%0d_lat", r, k), 64'(lat), 64'(1 + 63 / r));
        chk($sformatf("rnd_r%0d_k%0d_flags", r, k), {62'd0, ev, cv}, 64'd0);
      end
    end

    // Abort with start at RUN cycle 10
    do_start(64'h1234, 64'd3, 64'd5);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_pre", 64'(busy), 64'd1);
    do_start(64'h55, 64'd3, 64'd5);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_q", q_out, 64'h55);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_q_hold", q_out, 64'h55);
    run_step(lat, to, bs, ev, cv, da);
    chk("abort_next_q", q_out, m_prev(64'h55, 1, 64'd5));
    chk("abort_next_lat", 64'(lat), 64'd64);

    // Step while busy is ignored
    do_start(64'h117, 64'h11, 64'd7);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    cnt = 1;
    repeat (3) begin @(negedge clk); cnt++; end
    step = 1'b1;
    @(negedge clk);
    cnt++;
    step = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin @(negedge clk); cnt++; end
    chk("busystep_done", 64'(done), 64'd1);
    chk("busystep_lat", 64'(cnt), 64'd16);
    chk("busystep_q", q_out, 64'h10);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("busystep_no_extra", 64'(seen), 64'd0);
    chk("busystep_q_hold", q_out, 64'h10);

    // start and step together: only the load happens
    start = 1'b1; step = 1'b1; q_in = 64'h999; a = 64'h11; b = 64'd7;
    @(negedge clk);
    start = 1'b0; step = 1'b0;
    chk("startstep_busy", 64'(busy), 64'd0);
    chk("startstep_q", q_out, 64'h999);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("startstep_idle", 64'(seen), 64'd0);

    // Reset in the middle of RUN
    do_start(64'h1234, 64'h11, 64'd7);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_q", q_out, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // r was cleared by reset, so a step is refused
    run_step(lat, to, bs, ev, cv, da);
    chk("postrst_err", 64'(ev), 64'd1);
    chk("postrst_q", q_out, 64'd0);
    chk("postrst_busy", 64'(bs), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
